// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: RUN/SET mode controller and 1 s time base for the
// six-digit BCD time-of-day counter (HH:MM:SS).
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   key_vld    [0] mode toggle, [1] digit advance, [2] digit increment
//   set_mode   1 = SET, 0 = RUN
//   digit_sel  selected digit, 0 = seconds units .. 5 = hours tens
//   inc_pulse  one-hot one-cycle increment command per digit
//   sec_tick   one-cycle 1 s advance pulse (RUN only)
//   blank_mask 1 = blank that display digit (SET blink)
//
// Optional: define CLOCK_SET_TIMEOUT_EN to leave SET automatically
// after TIMEOUT_S idle seconds.
module clock_set_ctrl #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BLINK_HALF = 12_500_000,
  parameter int TIMEOUT_S  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_vld,
  output logic       set_mode,
  output logic [2:0] digit_sel,
  output logic [5:0] inc_pulse,
  output logic       sec_tick,
  output logic [5:0] blank_mask
);

  localparam int PW =
    (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BW =
    (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [PW-1:0] PRE_MAX =
    PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLK_MAX =
    BW'(BLINK_HALF - 1);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_pre;
  logic [PW-1:0] w_pre_nxt;
  logic [BW-1:0] r_bcnt;
  logic [BW-1:0] w_bcnt_nxt;
  logic          r_phase;
  logic          w_phase_nxt;
  logic [2:0]    r_sel;
  logic [2:0]    w_sel_nxt;
  logic [5:0]    r_inc;
  logic [5:0]    w_inc_nxt;
  logic          r_tick;
  logic          w_tick_nxt;
  logic [5:0]    r_blank;
  logic [5:0]    w_blank_nxt;

  logic w_mode;
  logic w_adv;
  logic w_incr;
  logic w_touch;
  logic w_idle_key;
  logic w_timeout;

  assign w_mode     = key_vld[0];
  assign w_adv      = key_vld[1];
  assign w_incr     = key_vld[2];
  // digit keys restart the blink so the edited digit stays visible
  assign w_touch    = w_adv | w_incr;
  assign w_idle_key = ~(|key_vld);

`ifdef CLOCK_SET_TIMEOUT_EN
  localparam int IDLE_LIM_I = TIMEOUT_S * CLK_HZ;
  localparam int IW = $clog2(IDLE_LIM_I + 1);
  localparam logic [IW-1:0] IDLE_LIM =
    IW'(IDLE_LIM_I);

  logic [IW-1:0] r_idle;
  logic [IW-1:0] w_idle_nxt;
  logic [IW-1:0] w_idle_inc;

  assign w_idle_inc = r_idle + IW'(1);
  assign w_timeout  = w_idle_key &&
                      (w_idle_inc == IDLE_LIM);
`else
  logic w_unused_to;

  assign w_unused_to = w_idle_key &
                       (TIMEOUT_S > 0);
  assign w_timeout   = 1'b0;
`endif

  function automatic logic [5:0] f_onehot(
    input logic [2:0] d
  );
    f_onehot = 6'b000001 << d;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_pre   <= '0;
      r_bcnt  <= '0;
      r_phase <= 1'b0;
      r_sel   <= '0;
      r_inc   <= '0;
      r_tick  <= 1'b0;
      r_blank <= '0;
`ifdef CLOCK_SET_TIMEOUT_EN
      r_idle  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_pre   <= w_pre_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_phase <= w_phase_nxt;
      r_sel   <= w_sel_nxt;
      r_inc   <= w_inc_nxt;
      r_tick  <= w_tick_nxt;
      r_blank <= w_blank_nxt;
`ifdef CLOCK_SET_TIMEOUT_EN
      r_idle  <= w_idle_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_tick_nxt  = 1'b0;
    w_sel_nxt   = r_sel;
    w_inc_nxt   = '0;
    w_bcnt_nxt  = r_bcnt;
    w_phase_nxt = r_phase;
`ifdef CLOCK_SET_TIMEOUT_EN
    w_idle_nxt  = r_idle;
`endif

    unique case (r_state)
      ST_RUN: begin
        if (w_mode) begin
          // mode change swallows any tick due now
          w_state_nxt = ST_SET;
          w_pre_nxt   = '0;
          w_sel_nxt   = '0;
          w_bcnt_nxt  = '0;
          w_phase_nxt = 1'b0;
`ifdef CLOCK_SET_TIMEOUT_EN
          w_idle_nxt  = '0;
`endif
        end else if (r_pre == PRE_MAX) begin
          w_pre_nxt  = '0;
          w_tick_nxt = 1'b1;
        end else begin
          w_pre_nxt = r_pre + PW'(1);
        end
      end

      ST_SET: begin
        w_pre_nxt = '0;
        if (w_mode || w_timeout) begin
          w_state_nxt = ST_RUN;
          w_bcnt_nxt  = '0;
          w_phase_nxt = 1'b0;
`ifdef CLOCK_SET_TIMEOUT_EN
          w_idle_nxt  = '0;
`endif
        end else begin
          // increment uses the digit selected
          // before a same-cycle advance
          if (w_incr) begin
            w_inc_nxt = f_onehot(r_sel);
          end
          if (w_adv) begin
            w_sel_nxt = (r_sel == 3'd5) ?
                        3'd0 : r_sel + 3'd1;
          end
          if (w_touch) begin
            w_bcnt_nxt  = '0;
            w_phase_nxt = 1'b0;
          end else if (r_bcnt == BLK_MAX) begin
            w_bcnt_nxt  = '0;
            w_phase_nxt = ~r_phase;
          end else begin
            w_bcnt_nxt = r_bcnt + BW'(1);
          end
`ifdef CLOCK_SET_TIMEOUT_EN
          w_idle_nxt = w_touch ? '0 : w_idle_inc;
`endif
        end
      end

      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase

    // registered from next-state values so the
    // mask lines up with phase and digit_sel
    w_blank_nxt = '0;
    if ((w_state_nxt == ST_SET) && w_phase_nxt) begin
      w_blank_nxt = f_onehot(w_sel_nxt);
    end
  end

  assign set_mode   = (r_state == ST_SET);
  assign digit_sel  = r_sel;
  assign inc_pulse  = r_inc;
  assign sec_tick   = r_tick;
  assign blank_mask = r_blank;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed plus random key stimulus
// against a cycle-age reference model of clock_set_ctrl.
module tb_clock_set_ctrl;

  localparam int CLK_HZ     = 10;
  localparam int BLINK_HALF = 3;
  localparam int TIMEOUT_S  = 2;
  localparam int LIMIT      = CLK_HZ * TIMEOUT_S;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] key_vld = 3'b000;
  logic       set_mode;
  logic [2:0] digit_sel;
  logic [5:0] inc_pulse;
  logic       sec_tick;
  logic [5:0] blank_mask;

  clock_set_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .BLINK_HALF(BLINK_HALF),
    .TIMEOUT_S (TIMEOUT_S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_vld   (key_vld),
    .set_mode  (set_mode),
    .digit_sel (digit_sel),
    .inc_pulse (inc_pulse),
    .sec_tick  (sec_tick),
    .blank_mask(blank_mask)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // model: ages in cycles rather than counters
  bit         m_set;
  int         m_sel;
  int         m_age;
  int         m_blink;
  int         m_last;
  int         m_cyc;
  logic [5:0] e_inc;
  bit         e_tick;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc %0d got %0h exp %0h",
               tag, m_cyc, got, exp);
    end
  endtask

  task automatic m_reset();
    m_set   = 1'b0;
    m_sel   = 0;
    m_age   = 0;
    m_blink = 0;
    m_last  = 0;
    m_cyc   = 0;
    e_inc   = '0;
    e_tick  = 1'b0;
  endtask

  task automatic m_edge(input logic [2:0] k);
    bit to;
    to     = 1'b0;
    e_inc  = '0;
    e_tick = 1'b0;
    m_cyc++;
    if (!m_set) begin
      if (k[0]) begin
        m_set   = 1'b1;
        m_sel   = 0;
        m_blink = 0;
        m_last  = m_cyc;
      end else begin
        m_age++;
        e_tick = (m_age % CLK_HZ) == 0;
      end
    end else begin
`ifdef CLOCK_SET_TIMEOUT_EN
      to = (k == 3'b000) &&
           ((m_cyc - m_last) >= LIMIT);
`endif
      if (k[0] || to) begin
        m_set = 1'b0;
        m_age = 0;
      end else begin
        if (k[2]) e_inc = 6'b000001 << m_sel;
        if (k[1]) m_sel = (m_sel + 1) % 6;
        if (k[1] || k[2]) begin
          m_blink = 0;
          m_last  = m_cyc;
        end else begin
          m_blink++;
        end
      end
    end
  endtask

  task automatic check_all(input string ph);
    logic [5:0] e_blank;
    e_blank = '0;
    if (m_set && ((m_blink / BLINK_HALF) % 2 == 1))
      e_blank = 6'b000001 << m_sel;
    chk({ph, ".mode"},  set_mode,   m_set);
    chk({ph, ".sel"},   digit_sel,  m_sel);
    chk({ph, ".inc"},   inc_pulse,  e_inc);
    chk({ph, ".tick"},  sec_tick,   e_tick);
    chk({ph, ".blank"}, blank_mask, e_blank);
  endtask

  task automatic step(input logic [2:0] k);
    key_vld = k;
    @(posedge clk);
    m_edge(k);
    #1;
    key_vld = 3'b000;
    check_all("step");
  endtask

  // asserted between edges: outputs must clear at once
  task automatic apply_reset(input int edges);
    #2;
    rst     = 1'b1;
    key_vld = 3'b000;
    #1;
    m_reset();
    check_all("rst");
    repeat (edges) @(posedge clk);
    #1;
    check_all("rsthold");
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] k;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("init");
    rst = 1'b0;

    // ticks at 10, 20, 30
    repeat (35) step(3'b000);
    apply_reset(1);
    repeat (15) step(3'b000);
    apply_reset(2);
    repeat (12) step(3'b000);
    // reset lands while a tick is high
    apply_reset(1);
    repeat (10) step(3'b000);
    chk("tick_hi", sec_tick, 1'b1);
    apply_reset(1);

    // enter SET, increment seconds units
    repeat (5) step(3'b000);
    step(3'b001);
    repeat (2) step(3'b000);
    step(3'b100);
    step(3'b000);

    // walk the digits, then inc+adv together
    repeat (6) step(3'b010);
    repeat (3) step(3'b010);
    step(3'b110);
    step(3'b000);

    // blink on digit 2, key during blank phase
    repeat (4) step(3'b010);
    repeat (10) step(3'b000);
    step(3'b100);
    repeat (4) step(3'b000);
    step(3'b100);
    repeat (7) step(3'b000);

    // mode keys combined with digit keys
    step(3'b001);
    repeat (3) step(3'b000);
    step(3'b101);
    step(3'b010);
    step(3'b000);
    step(3'b111);
    repeat (12) step(3'b000);

    // idle in SET
    step(3'b001);
    repeat (100) step(3'b000);
    if (set_mode) step(3'b001);
    repeat (12) step(3'b000);

    // random keys with occasional resets
    repeat (3000) begin
      if ($urandom_range(0, 299) == 0) begin
        apply_reset($urandom_range(1, 3));
      end else begin
        k = 3'b000;
        k[0] = ($urandom_range(0, 39) == 0);
        k[1] = ($urandom_range(0, 7) == 0);
        k[2] = ($urandom_range(0, 7) == 0);
        step(k);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
